// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line-granular memory controller.
// Optional statistics outputs are enabled with LINE_MEM_STATS_EN.
package line_mem_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_ADDR_LEN      = 9;
  localparam int DEF_MEM_LATENCY   = 16;
  localparam int DATA_W            = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Word index inside the SRAM is {line_addr, beat}.
  function automatic logic [31:0] word_idx(input logic [31:0] line_addr,
                                           input logic [31:0] beat,
                                           input int          beat_bits);
    return (line_addr << beat_bits) | beat;
  endfunction

endpackage

// File: rtl/word_sram.sv
// Single-port word SRAM, synchronous write, 1-cycle registered read.
// Words are stored XORed with their own index, so zeroed storage reads back as index w = w.
module word_sram
  import line_mem_pkg::*;
#(
  parameter int IDX_W = DEF_ADDR_LEN + DEF_LINE_ADDR_LEN
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << IDX_W)-1];
  logic [DATA_W-1:0] w_scramble;

  assign w_scramble = DATA_W'(i_addr);

  // Storage write and registered read; storage is never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata ^ w_scramble;
    end
    o_rdata <= r_mem[i_addr] ^ w_scramble;
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Whole-line read/write controller with fixed access latency in front of a word SRAM.
// Define LINE_MEM_STATS_EN to add rd_line_cnt / wr_line_cnt completion counters.
module line_mem_ctrl
  import line_mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_LEN      = DEF_ADDR_LEN,
  parameter int MEM_LATENCY   = DEF_MEM_LATENCY
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ADDR_LEN-1:0]                       addr,
  input  logic                                      rd_req,
  input  logic                                      wr_req,
  input  logic [(1<<LINE_ADDR_LEN)-1:0][DATA_W-1:0] wr_line,
  output logic [(1<<LINE_ADDR_LEN)-1:0][DATA_W-1:0] rd_line,
  output logic                                      gnt
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]                               rd_line_cnt,
  output logic [31:0]                               wr_line_cnt
`endif
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int IDX_W     = ADDR_LEN + LINE_ADDR_LEN;
  localparam int BEAT_W    = LINE_ADDR_LEN + 1;
  localparam int LAT_W     = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  typedef logic [LINE_SIZE-1:0][DATA_W-1:0] line_t;

  state_e                   r_state, w_next_state;
  logic                     r_is_wr;
  logic [ADDR_LEN-1:0]      r_addr;
  line_t                    r_wr_line, r_shadow, w_shadow_next;
  logic [BEAT_W-1:0]        r_beat;
  logic [LAT_W-1:0]         r_lat_cnt;
  logic                     w_accept, w_sram_we;
  logic [IDX_W-1:0]         w_sram_addr;
  logic [DATA_W-1:0]        w_sram_wdata, w_sram_rdata;
  logic [LINE_ADDR_LEN-1:0] w_beat_idx, w_cap_idx;

  assign w_beat_idx   = r_beat[LINE_ADDR_LEN-1:0];
  assign w_cap_idx    = LINE_ADDR_LEN'(r_beat - BEAT_W'(1));
  assign w_sram_addr  = IDX_W'(word_idx(32'(r_addr), 32'(w_beat_idx), LINE_ADDR_LEN));
  assign w_sram_wdata = r_wr_line[w_beat_idx];

  word_sram #(.IDX_W(IDX_W)) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_sram_rdata)
  );

  // Next-state and SRAM write strobe.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_sram_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          w_accept     = 1'b1;
          w_next_state = (MEM_LATENCY == 0) ? ST_XFER : ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == LAT_W'(MEM_LATENCY - 1)) w_next_state = ST_XFER;
        else                                      w_next_state = ST_WAIT;
      end
      ST_XFER: begin
        if (r_is_wr) begin
          w_sram_we = 1'b1;
          if (r_beat == BEAT_W'(LINE_SIZE - 1)) w_next_state = ST_DONE;
          else                                  w_next_state = ST_XFER;
        end else begin
          // Reads need one extra drain beat for the SRAM's registered output.
          if (r_beat == BEAT_W'(LINE_SIZE)) w_next_state = ST_DONE;
          else                              w_next_state = ST_XFER;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture the word read on the previous beat into the shadow line.
  always_comb begin
    w_shadow_next = r_shadow;
    if (r_state == ST_XFER && !r_is_wr && r_beat != '0) begin
      w_shadow_next[w_cap_idx] = w_sram_rdata;
    end else begin
      w_shadow_next = r_shadow;
    end
  end

  // State register, completion pulse and the visible read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      gnt     <= 1'b0;
      rd_line <= '0;
    end else begin
      r_state <= w_next_state;
      gnt     <= (w_next_state == ST_DONE);
      if (r_state == ST_XFER && !r_is_wr && w_next_state == ST_DONE) begin
        rd_line <= w_shadow_next;
      end
    end
  end

  // Counters, shadow line and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat    <= '0;
      r_lat_cnt <= '0;
      r_shadow  <= '0;
      r_addr    <= '0;
      r_is_wr   <= 1'b0;
      r_wr_line <= '0;
    end else begin
      r_lat_cnt <= (r_state == ST_WAIT) ? r_lat_cnt + LAT_W'(1) : '0;
      r_beat    <= (r_state == ST_XFER) ? r_beat + BEAT_W'(1) : '0;
      r_shadow  <= w_shadow_next;
      if (w_accept) begin
        r_addr  <= addr;
        r_is_wr <= wr_req;
        if (wr_req) r_wr_line <= wr_line;
      end
    end
  end

`ifdef LINE_MEM_STATS_EN
  // Completed-line counters, bumped in the DONE cycle of each op.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line_cnt <= 32'd0;
      wr_line_cnt <= 32'd0;
    end else if (r_state == ST_DONE) begin
      if (r_is_wr) wr_line_cnt <= wr_line_cnt + 32'd1;
      else         rd_line_cnt <= rd_line_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: default-latency and zero-latency instances against a transaction-level model.
// Counter outputs are checked when LINE_MEM_STATS_EN is defined.
module tb_line_mem_ctrl;

  localparam int LA = 3;
  localparam int LS = 8;
  localparam int AL = 9;
  localparam int NW = 1 << (AL + LA);

  typedef logic [LS-1:0][31:0] line_t;

  logic          clk = 1'b0;
  logic          rst     [2];
  logic [AL-1:0] addr    [2];
  logic          rd_req  [2];
  logic          wr_req  [2];
  line_t         wr_line [2];
  line_t         rd_line [2];
  logic          gnt     [2];
`ifdef LINE_MEM_STATS_EN
  logic [31:0]   rd_cnt  [2];
  logic [31:0]   wr_cnt  [2];
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Model: memory contents plus when each instance is idle, grants, and shows a new line.
  logic [31:0] mem_m [2][NW];
  int          m_idle_from [2] = '{0, 0};
  int          m_gnt_at    [2] = '{-1, -1};
  int          m_line_at   [2] = '{-1, -1};
  line_t       m_rd_line   [2];
  line_t       m_next_line [2];

  always #5 clk = ~clk;

  line_mem_ctrl u_dut0 (
    .clk(clk), .rst(rst[0]), .addr(addr[0]), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
    .wr_line(wr_line[0]), .rd_line(rd_line[0]), .gnt(gnt[0])
`ifdef LINE_MEM_STATS_EN
    , .rd_line_cnt(rd_cnt[0]), .wr_line_cnt(wr_cnt[0])
`endif
  );

  line_mem_ctrl #(.MEM_LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .addr(addr[1]), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
    .wr_line(wr_line[1]), .rd_line(rd_line[1]), .gnt(gnt[1])
`ifdef LINE_MEM_STATS_EN
    , .rd_line_cnt(rd_cnt[1]), .wr_line_cnt(wr_cnt[1])
`endif
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  function automatic line_t model_line(input int i, input logic [AL-1:0] a);
    line_t r;
    for (int b = 0; b < LS; b++) r[b] = mem_m[i][{a, 3'(b)}];
    return r;
  endfunction

  function automatic line_t mk(input logic [31:0] base);
    line_t r;
    for (int b = 0; b < LS; b++) r[b] = base + 32'(b);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: an accepted op grants after a fixed number of cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_idle_from[i] <= cyc + 1;
        m_gnt_at[i]    <= -1;
        m_line_at[i]   <= -1;
        m_rd_line[i]   <= '0;
      end else begin
        if (m_line_at[i] == cyc + 1) m_rd_line[i] <= m_next_line[i];
        if (cyc >= m_idle_from[i] && (wr_req[i] || rd_req[i])) begin
          if (wr_req[i]) begin
            m_gnt_at[i]    <= cyc + 1 + lat_of(i) + LS;
            m_idle_from[i] <= cyc + 2 + lat_of(i) + LS;
            for (int b = 0; b < LS; b++) mem_m[i][{addr[i], 3'(b)}] <= wr_line[i][b];
          end else begin
            m_gnt_at[i]    <= cyc + 2 + lat_of(i) + LS;
            m_idle_from[i] <= cyc + 3 + lat_of(i) + LS;
            m_line_at[i]   <= cyc + 2 + lat_of(i) + LS;
            m_next_line[i] <= model_line(i, addr[i]);
          end
        end
      end
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gnt%0d@%0d", i, cyc), 256'(gnt[i]), 256'(m_gnt_at[i] == cyc));
        chk($sformatf("rd_line%0d@%0d", i, cyc), rd_line[i], m_rd_line[i]);
      end
    end
  end

  // Present one request, scramble addr/wr_line after accept, wait for gnt, check latency.
  task automatic do_req(input int i, input bit wr, input bit rd, input logic [AL-1:0] a,
                        input line_t wl, input int exp_lat, input string nm);
    int start;
    bit seen;
    @(negedge clk);
    addr[i]    = a;
    wr_line[i] = wl;
    wr_req[i]  = wr;
    rd_req[i]  = rd;
    start      = cyc;
    seen       = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      addr[i]    = ~a;
      wr_line[i] = '1;
      if (gnt[i]) seen = 1'b1;
    end
    wr_req[i] = 1'b0;
    rd_req[i] = 1'b0;
    chk({nm, " latency"}, seen ? 256'(cyc - start) : 256'(-1), 256'(exp_lat));
  endtask

  task automatic count_gnt(input int i, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gnt[i]) cnt++;
    end
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < NW; w++) mem_m[i][w] = 32'(w);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; addr[i] = '0; rd_req[i] = 1'b0; wr_req[i] = 1'b0; wr_line[i] = '0;
    end
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("reset gnt", 256'(gnt[0]), 256'(0));
    chk("reset rd_line", rd_line[0], '0);

    do_req(0, 1'b0, 1'b1, 9'd5, '0, 26, "rd5");
    chk("rd5 line", rd_line[0], mk(32'd40));
    do_req(0, 1'b1, 1'b0, 9'd7, mk(32'hA000_0000), 25, "wr7");
    do_req(0, 1'b0, 1'b1, 9'd7, '0, 26, "rd7");
    chk("rd7 line", rd_line[0], mk(32'hA000_0000));
    do_req(0, 1'b0, 1'b1, 9'd6, '0, 26, "rd6");
    chk("rd6 line", rd_line[0], mk(32'd48));

    do_req(0, 1'b1, 1'b1, 9'd3, mk(32'hB000_0000), 25, "wr+rd3");
    count_gnt(0, 40, pulses);
    chk("wr+rd3 extra gnt", 256'(pulses), 256'(0));
    chk("wr+rd3 rd_line kept", rd_line[0], mk(32'd48));
    do_req(0, 1'b0, 1'b1, 9'd3, '0, 26, "rd3");
    chk("rd3 line", rd_line[0], mk(32'hB000_0000));

    do_req(0, 1'b1, 1'b0, 9'd2, mk(32'hC000_0000), 25, "wr2");
    do_req(0, 1'b0, 1'b1, 9'd2, '0, 26, "rd2 b2b");
    chk("rd2 line", rd_line[0], mk(32'hC000_0000));
`ifdef LINE_MEM_STATS_EN
    @(negedge clk);
    chk("stats0 rd", 256'(rd_cnt[0]), 256'(5));
    chk("stats0 wr", 256'(wr_cnt[0]), 256'(3));
`endif

    do_req(1, 1'b1, 1'b0, 9'd1, mk(32'hD000_0000), 9, "l0 wr1");
    do_req(1, 1'b0, 1'b1, 9'd1, '0, 10, "l0 rd1");
    chk("l0 rd1 line", rd_line[1], mk(32'hD000_0000));
    @(negedge clk);
`ifdef LINE_MEM_STATS_EN
    chk("stats1 rd", 256'(rd_cnt[1]), 256'(1));
    chk("stats1 wr", 256'(wr_cnt[1]), 256'(1));
`endif

    // Reset in the middle of a zero-latency read transfer.
    @(negedge clk);
    addr[1]   = 9'd4;
    rd_req[1] = 1'b1;
    repeat (4) @(negedge clk);
    rd_req[1] = 1'b0;
    rst[1]    = 1'b1;
    @(negedge clk);
    rst[1]    = 1'b0;
    chk("mid rst rd_line", rd_line[1], '0);
`ifdef LINE_MEM_STATS_EN
    chk("mid rst stats rd", 256'(rd_cnt[1]), 256'(0));
    chk("mid rst stats wr", 256'(wr_cnt[1]), 256'(0));
`endif
    count_gnt(1, 20, pulses);
    chk("mid rst no gnt", 256'(pulses), 256'(0));
    do_req(1, 1'b0, 1'b1, 9'd4, '0, 10, "l0 rd4");
    chk("l0 rd4 line", rd_line[1], mk(32'd32));
    @(negedge clk);
`ifdef LINE_MEM_STATS_EN
    chk("post rst stats rd", 256'(rd_cnt[1]), 256'(1));
    chk("post rst stats wr", 256'(wr_cnt[1]), 256'(0));
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_ctrl.md
Name: line_mem_ctrl

Overview:
Line-granular main-memory controller that sits directly downstream of the set-associative cache and services its swap-in and swap-out requests.
- Accepts one whole-line read or write per request.
- Models a fixed access latency, then transfers the line beat-by-beat into or out of a word-wide single-port SRAM.
- Completes each request with a one-cycle gnt pulse.
- Port shape matches the cache's memory-side interface, so the controller drops in as its backing store.

Parameters:
- LINE_ADDR_LEN, default 3: log2 words per line; LINE_SIZE = 2^LINE_ADDR_LEN.
- ADDR_LEN, default 9: line address width; storage holds 2^ADDR_LEN lines.
- MEM_LATENCY, default 16: wait cycles before a transfer starts; 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- addr  in  ADDR_LEN  line address, sampled at accept.
- rd_req  in  1  line read request, level, held until gnt.
- wr_req  in  1  line write request, level, held until gnt.
- wr_line  in  32 x LINE_SIZE  write line, sampled at accept.
- rd_line  out  32 x LINE_SIZE  last line read; stable between read completions.
- gnt  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: gnt=0, all rd_line words=0, state IDLE, counters 0. Storage is not affected by rst.
- Simulation-time storage init: word index w holds value w.
- Word index is {line_addr, beat}, width ADDR_LEN+LINE_ADDR_LEN.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - If wr_req or rd_req is high, latch addr, the op, and (for writes) wr_line.
  - Go to WAIT, or straight to XFER when MEM_LATENCY=0.
  - wr_req has priority when both are high; only the write is serviced, and rd_req must be re-presented.
- WAIT: count MEM_LATENCY cycles, then go to XFER.
- XFER, write: one SRAM word write per cycle, beats 0..LINE_SIZE-1, for LINE_SIZE cycles.
- XFER, read:
  - SRAM read latency is 1 cycle.
  - Issue reads for beats 0..LINE_SIZE-1, capturing each word one cycle later into a shadow line.
  - Takes LINE_SIZE+1 cycles.
  - rd_line is updated from the shadow only on entry to DONE, so rd_line never shows a partial line.
- DONE: gnt=1 for exactly this cycle, then go unconditionally to IDLE.
  - A request still high during DONE is not re-accepted.
  - Requests are next sampled in the following IDLE cycle.
- Timing, with cycle 0 = first IDLE cycle in which a request is high:
  - Write: gnt in cycle 1+MEM_LATENCY+LINE_SIZE.
  - Read: gnt in cycle 2+MEM_LATENCY+LINE_SIZE.
- Back-to-back: a write gnt followed by a read request in the next cycle is accepted in that cycle (the cache's SWAP_OUT to SWAP_IN sequence).
- Changes on addr or wr_line after accept are ignored.
- Dropping a request before gnt is illegal. The controller completes the latched op regardless.
- rst mid-operation: return to IDLE and clear rd_line and gnt. Any SRAM beats already written stay written, so a partial line write is possible and acceptable.
- Counter wrap: the beat counter is LINE_ADDR_LEN+1 bits wide, sized for the read drain beat. The latency counter is $clog2(MEM_LATENCY+1) bits wide.

Optional Feature:
LINE_MEM_STATS_EN
- Defined:
  - Adds outputs rd_line_cnt[31:0] and wr_line_cnt[31:0], reset to 0.
  - Each increments on the DONE cycle of its op type and wraps at 2^32.
- Undefined: the ports and counters are absent and the core behaviour is identical.

Decomposition:
- Package line_mem_pkg:
  - State enum type.
  - Word-index composition function.
  - Default-parameter localparams.
- Sub-module word_sram: single-port, 32-bit, depth 2^(ADDR_LEN+LINE_ADDR_LEN), synchronous write, 1-cycle registered read, holds the init pattern.
- The FSM, counters, and line latches stay in line_mem_ctrl.

Test Plan:
- Defaults. Hold rd_req with addr=5 from cycle 0 -> gnt only in cycle 26; rd_line[i]=40+i.
- Write wr_line[i]=32'hA000_0000+i to addr=7 -> gnt in cycle 25. A following read of addr=7 returns the same words, and addr=6 still reads 48+i.
- wr_req and rd_req both high with addr=3 -> only the write is serviced, one gnt. Re-issued rd_req reads back the written data.
- Write gnt, then rd_req asserted the next cycle with addr=2 -> read accepted immediately; its gnt comes 26 cycles after the read's first request cycle. rd_line is unchanged until that gnt.
- MEM_LATENCY=0 -> write gnt in cycle 9, read gnt in cycle 10. Assert rst during a read's XFER -> gnt never pulses, rd_line=0, and the next request behaves as from reset.
- With LINE_MEM_STATS_EN: 3 reads and 2 writes -> rd_line_cnt=3, wr_line_cnt=2. After rst both counters are 0.
